// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: machine width, PC stepping and the fetch
// buffer entry that travels from the fetch stage to the decoder.
package cpu_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;
  localparam logic [XLEN-1:0] RESET_PC = '0;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Branch targets may carry low bits; instruction fetch is word addressed.
  function automatic logic [XLEN-1:0] alignWord(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, redirect
// from the back end, and the valid/ready channel into the decoder.
interface instr_fetch_unit_if #(parameter int XLEN = cpu_pkg::XLEN);

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_instr;
  logic [XLEN-1:0] if_pc;

  modport master (
    output imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, if_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, if_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, instr} entries; flush empties
// it in one cycle when the fetch stream is redirected.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q, wrPtr_d;
  logic [AW-1:0]    rdPtr_q, rdPtr_d;
  logic [AW:0]      count_q, count_d;
  logic             doPush, doPop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rdPtr_q];
  assign doPush  = push_i && !full_o && !flush_i;
  assign doPop   = pop_i && !empty_o && !flush_i;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (flush_i) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (doPush) wrPtr_d = wrPtr_q + AW'(1);
      if (doPop)  rdPtr_d = rdPtr_q + AW'(1);
      count_d = count_q + (AW+1)'(doPush) - (AW+1)'(doPop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= data_i;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the fetch PC, issues word requests under a credit limit,
// buffers in-order responses and discards words made stale by a redirect.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int              XLEN       = cpu_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC   = cpu_pkg::RESET_PC,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  instr_fetch_unit_if.master  fetchBus_io
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = $bits(fetch_entry_t);

  logic [XLEN-1:0] fetchPc_q, fetchPc_d;
  logic [XLEN-1:0] rspPc_q, rspPc_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic [CW-1:0]   fifoCount;
  logic [CW:0]     slotsUsed;
  logic [XLEN-1:0] redirectTarget;
  logic            fifoFull, fifoEmpty;
  logic            redirect, reqFire, rspKeep, rspDrop, pushEn, popEn, canIssue;
  fetch_entry_t    pushEntry, headEntry;

  assign redirect       = fetchBus_io.redirect_valid;
  assign redirectTarget = alignWord(fetchBus_io.redirect_pc);

  // A pop this cycle frees a slot, which is what sustains one fetch per cycle.
  assign popEn     = !redirect && !fifoEmpty && fetchBus_io.if_ready;
  assign slotsUsed = {1'b0, inflight_q} + {1'b0, fifoCount} - (CW+1)'(popEn);
  assign canIssue  = slotsUsed < (CW+1)'(FIFO_DEPTH);

  assign fetchBus_io.imem_req_valid = !rst && !redirect && canIssue;
  assign fetchBus_io.imem_req_addr  = fetchPc_q;
  assign reqFire = fetchBus_io.imem_req_valid && fetchBus_io.imem_req_ready;

  assign rspDrop   = fetchBus_io.imem_rsp_valid && (discard_q != '0);
  assign rspKeep   = fetchBus_io.imem_rsp_valid && (discard_q == '0);
  assign pushEn    = rspKeep && !redirect && !fifoFull;
  assign pushEntry = '{pc: rspPc_q, instr: fetchBus_io.imem_rsp_data};

  assign fetchBus_io.if_valid = !fifoEmpty;
  assign fetchBus_io.if_instr = fifoEmpty ? '0 : headEntry.instr;
  assign fetchBus_io.if_pc    = fifoEmpty ? '0 : headEntry.pc;

  // inflight counts live requests only; on redirect they all become discards.
  always_comb begin
    fetchPc_d  = fetchPc_q;
    rspPc_d    = rspPc_q;
    inflight_d = inflight_q;
    discard_d  = discard_q;
    if (redirect) begin
      fetchPc_d  = redirectTarget;
      rspPc_d    = redirectTarget;
      inflight_d = '0;
      discard_d  = discard_q + inflight_q - CW'(fetchBus_io.imem_rsp_valid);
    end else begin
      if (reqFire) fetchPc_d = fetchPc_q + XLEN'(PC_STEP);
      if (rspKeep) rspPc_d   = rspPc_q + XLEN'(PC_STEP);
      inflight_d = inflight_q + CW'(reqFire) - CW'(rspKeep);
      if (rspDrop) discard_d = discard_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetchPc_q  <= RESET_PC;
      rspPc_q    <= RESET_PC;
      inflight_q <= '0;
      discard_q  <= '0;
    end else begin
      fetchPc_q  <= fetchPc_d;
      rspPc_q    <= rspPc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (pushEn),
    .pop_i   (popEn),
    .flush_i (redirect),
    .data_i  (pushEntry),
    .data_o  (headEntry),
    .count_o (fifoCount),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a queue-based instruction memory
// whose responses can be held back to build up outstanding requests.
module tb_instr_fetch_unit;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic memHold = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   fireCount;
  logic [31:0] pend [$];

  always #5 clk = ~clk;

  instr_fetch_unit_if #(.XLEN(32)) bus ();

  instr_fetch_unit #(
    .XLEN       (32),
    .RESET_PC   (32'hFFFF_FFFC),
    .FIFO_DEPTH (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fetchBus_io (bus)
  );

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    return addr ^ 32'hC0DE_0000;
  endfunction

  // Memory answers one cycle after acceptance unless memHold parks the queue.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pend.delete();
      bus.imem_rsp_valid <= 1'b0;
      bus.imem_rsp_data  <= '0;
      fireCount          <= 0;
    end else begin
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        pend.push_back(bus.imem_req_addr);
        fireCount <= fireCount + 1;
      end
      if (!memHold && pend.size() > 0) begin
        bus.imem_rsp_valid <= 1'b1;
        bus.imem_rsp_data  <= memWord(pend.pop_front());
      end else begin
        bus.imem_rsp_valid <= 1'b0;
      end
    end
  end

  task automatic applyStimulus(input logic memReady, input logic ifReady,
                               input logic redir, input logic [31:0] redirPc);
    bus.imem_req_ready = memReady;
    bus.if_ready       = ifReady;
    bus.redirect_valid = redir;
    bus.redirect_pc    = redirPc;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%08h expected=%08h", tag, observed, expected);
    end
  endtask

  task automatic waitIfValid(input int maxCycles, input string tag);
    int n = 0;
    while (!bus.if_valid && n < maxCycles) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, {31'b0, bus.if_valid}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    repeat (2) @(negedge clk);

    $display("[TB] reset state");
    checkOutput("rst_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
    checkOutput("rst_if_valid",  {31'b0, bus.if_valid},       32'd0);
    checkOutput("rst_if_instr",  bus.if_instr,                32'h0);
    checkOutput("rst_if_pc",     bus.if_pc,                   32'h0);
    checkOutput("rst_req_addr",  bus.imem_req_addr,           32'hFFFF_FFFC);

    $display("[TB] streaming with PC wrap");
    rst = 1'b0;
    #1;
    checkOutput("t1_req_valid", {31'b0, bus.imem_req_valid}, 32'd1);
    checkOutput("t1_addr0",     bus.imem_req_addr,           32'hFFFF_FFFC);
    @(negedge clk);
    checkOutput("t1_addr1",     bus.imem_req_addr,           32'h0000_0000);
    checkOutput("t1_if_empty",  {31'b0, bus.if_valid},       32'd0);
    @(negedge clk);
    checkOutput("t1_addr2",     bus.imem_req_addr,           32'h0000_0004);
    checkOutput("t1_if_valid",  {31'b0, bus.if_valid},       32'd1);
    checkOutput("t1_pc0",       bus.if_pc,                   32'hFFFF_FFFC);
    checkOutput("t1_instr0",    bus.if_instr,                32'h3F21_FFFC);
    @(negedge clk);
    checkOutput("t1_addr3",     bus.imem_req_addr,           32'h0000_0008);
    checkOutput("t1_pc1",       bus.if_pc,                   32'h0000_0000);
    checkOutput("t1_instr1",    bus.if_instr,                32'hC0DE_0000);
    @(negedge clk);
    checkOutput("t1_pc2",       bus.if_pc,                   32'h0000_0004);
    checkOutput("t1_instr2",    bus.if_instr,                32'hC0DE_0004);

    $display("[TB] mid-stream reset");
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    #1;
    checkOutput("t6_if_valid",  {31'b0, bus.if_valid},       32'd0);
    checkOutput("t6_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
    checkOutput("t6_if_pc",     bus.if_pc,                   32'h0);
    checkOutput("t6_req_addr",  bus.imem_req_addr,           32'hFFFF_FFFC);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    $display("[TB] decoder stall");
    repeat (10) @(negedge clk);
    checkOutput("t2_fires",     32'(fireCount),              32'd2);
    checkOutput("t2_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
    checkOutput("t2_if_valid",  {31'b0, bus.if_valid},       32'd1);
    checkOutput("t2_pc_held",   bus.if_pc,                   32'hFFFF_FFFC);
    checkOutput("t2_instr",     bus.if_instr,                32'h3F21_FFFC);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    #1;
    checkOutput("t2_next_addr", bus.imem_req_addr,           32'h0000_0004);
    @(negedge clk);
    checkOutput("t2_pc1",       bus.if_pc,                   32'h0000_0000);
    checkOutput("t2_instr1",    bus.if_instr,                32'hC0DE_0000);
    @(negedge clk);
    checkOutput("t2_pc2",       bus.if_pc,                   32'h0000_0004);
    checkOutput("t2_instr2",    bus.if_instr,                32'hC0DE_0004);

    $display("[TB] redirect with two in flight");
    memHold = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("t3_outstanding", 32'(pend.size()),            32'd2);
    checkOutput("t3_req_blocked", {31'b0, bus.imem_req_valid}, 32'd0);
    checkOutput("t3_drained",     {31'b0, bus.if_valid},       32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0100);
    memHold = 1'b0;
    #1;
    checkOutput("t3_no_req_at_n", {31'b0, bus.imem_req_valid}, 32'd0);
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    #1;
    checkOutput("t3_req_valid",   {31'b0, bus.imem_req_valid}, 32'd1);
    checkOutput("t3_req_addr",    bus.imem_req_addr,           32'h0000_0100);
    waitIfValid(8, "t3_wait_if");
    checkOutput("t3_pc0",         bus.if_pc,                   32'h0000_0100);
    checkOutput("t3_instr0",      bus.if_instr,                32'hC0DE_0100);
    @(negedge clk);
    checkOutput("t3_pc1",         bus.if_pc,                   32'h0000_0104);
    checkOutput("t3_instr1",      bus.if_instr,                32'hC0DE_0104);

    $display("[TB] unaligned redirect");
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0103);
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    #1;
    checkOutput("t4_req_addr",    bus.imem_req_addr,           32'h0000_0100);
    waitIfValid(8, "t4_wait_if");
    checkOutput("t4_pc0",         bus.if_pc,                   32'h0000_0100);
    checkOutput("t4_instr0",      bus.if_instr,                32'hC0DE_0100);

    $display("[TB] memory back-pressure");
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0200);
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    #1;
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("t5_valid_held%0d", i), {31'b0, bus.imem_req_valid}, 32'd1);
      checkOutput($sformatf("t5_addr_held%0d", i),  bus.imem_req_addr,           32'h0000_0200);
      @(negedge clk);
    end
    checkOutput("t5_if_empty",    {31'b0, bus.if_valid},       32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    waitIfValid(8, "t5_wait_if");
    checkOutput("t5_pc0",         bus.if_pc,                   32'h0000_0200);
    checkOutput("t5_instr0",      bus.if_instr,                32'hC0DE_0200);
    @(negedge clk);
    checkOutput("t5_pc1",         bus.if_pc,                   32'h0000_0204);
    checkOutput("t5_instr1",      bus.if_instr,                32'hC0DE_0204);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
